mod_mult_seq: RTL

- Parametrised, digit-serial modular multiplier. Computes (a*b) mod MOD for operands in [0, MOD-1]; defaults MOD=997, 10-bit operands.
- Scans operand b MSB-first, DIGIT bits per clock. Uses interleaved shift-add with conditional subtraction, so it needs no precomputed partial-product constant tables.
- Sits behind the mod-997 arithmetic datapath as a shared, area-lean multiplier with valid/ready handshakes on both sides.

---
 rtl/mod_mult_seq_if.sv | 24 ++
 rtl/mod_mult_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/mod_mult_seq_if.sv
// Handshake bundle for the digit-serial modular multiplier: operand request
// channel and result channel, each with valid/ready.
interface mod_mult_seq_if #(
    parameter int unsigned W = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
endinterface

// File: rtl/mod_mult_seq.sv
// Digit-serial (a*b) mod MOD: scans b MSB-first, DIGIT bits per clock, using
// interleaved shift-add with up to two conditional subtractions per bit.
module mod_mult_seq #(
    parameter int unsigned MOD   = 997,
    parameter int unsigned W     = 10,
    parameter int unsigned DIGIT = 3
) (
    input logic            clk,
    input logic            rst,
    mod_mult_seq_if.slave  bus
);
    localparam int unsigned NCYC = (W + DIGIT - 1) / DIGIT;
    localparam int unsigned BW   = NCYC * DIGIT;
    localparam int unsigned AW   = W + 2;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    localparam logic [W-1:0]  MOD_W = W'(MOD);
    localparam logic [AW-1:0] MOD_A = AW'(MOD);
    localparam logic [CW-1:0] LAST  = CW'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_reg;
    logic [BW-1:0]  b_reg;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_step;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   z_reg;
    logic           err_reg;
    logic           op_err;

    assign op_err = (bus.in_a >= MOD_W) || (bus.in_b >= MOD_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = op_err ? DONE : CALC;
            CALC: if (cnt == LAST)  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.out_z   = z_reg;
    assign bus.out_err = err_reg;

    // b_reg is shifted left each cycle, so the current digit is always its top bits.
    always_comb begin
        acc_step = acc;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            acc_step = (acc_step << 1) + (b_reg[BW-1-i] ? {2'b00, a_reg} : '0);
            if (acc_step >= MOD_A) acc_step = acc_step - MOD_A;
            if (acc_step >= MOD_A) acc_step = acc_step - MOD_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            z_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg <= bus.in_a;
                    b_reg <= BW'(bus.in_b);
                    acc   <= '0;
                    cnt   <= '0;
                    if (op_err) begin
                        z_reg   <= '0;
                        err_reg <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    b_reg <= b_reg << DIGIT;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        z_reg   <= acc_step[W-1:0];
                        err_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
